// File: rtl/cache_control.sv
// cache_control: two-way cache controller FSM sequencing hits, writebacks and line fills
module cache_control #(
    parameter int s_mask = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [s_mask-1:0] mem_byte_enable256,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp,
    output logic              pmem_addr_sel,
    input  logic [1:0]        cmp,
    input  logic [1:0]        valid,
    input  logic [1:0]        dirty,
    input  logic              lru,
    output logic              sel,
    output logic              data_in_sel,
    output logic [s_mask-1:0] write_en0,
    output logic [s_mask-1:0] write_en1,
    output logic [1:0]        load_tag,
    output logic              load_valid,
    output logic              load_dirty,
    output logic              load_lru,
    output logic [1:0]        valid_in,
    output logic [1:0]        dirty_in,
    output logic              lru_in
);
    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
    state_t state, next;
    logic [1:0] hits;
    logic hit, way, req;
    assign hits = cmp & valid;
    assign hit  = |hits;
    assign way  = ~hits[0];
    assign req  = mem_read | mem_write;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;
    always_comb begin
        next = state;
        mem_resp = 1'b0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_addr_sel = 1'b0;
        sel = 1'b0;
        data_in_sel = 1'b0;
        write_en0 = '0;
        write_en1 = '0;
        load_tag = 2'b00;
        load_valid = 1'b0;
        load_dirty = 1'b0;
        load_lru = 1'b0;
        valid_in = 2'b00;
        dirty_in = 2'b00;
        lru_in = 1'b0;
        case (state)
            IDLE: next = req ? CHECK : IDLE;
            CHECK: begin
                if (!req) next = IDLE;
                else if (hit) begin
                    sel = way;
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_in = ~way;
                    next = IDLE;
                    if (mem_write) begin
                        write_en0 = way ? '0 : mem_byte_enable256;
                        write_en1 = way ? mem_byte_enable256 : '0;
                        load_dirty = 1'b1;
                        dirty_in = way ? {1'b1, dirty[0]} : {dirty[1], 1'b1};
                    end
                end else next = (valid[lru] & dirty[lru]) ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                pmem_addr_sel = 1'b1;
                sel = lru;
                next = pmem_resp ? FILL : WRITEBACK;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    data_in_sel = 1'b1;
                    write_en0 = lru ? '0 : '1;
                    write_en1 = lru ? '1 : '0;
                    load_tag = lru ? 2'b10 : 2'b01;
                    load_valid = 1'b1;
                    valid_in = lru ? {1'b1, valid[0]} : {valid[1], 1'b1};
                    load_dirty = 1'b1;
                    dirty_in = lru ? {1'b0, dirty[0]} : {dirty[1], 1'b0};
                    next = CHECK;
                end
            end
        endcase
    end
endmodule
